// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin demux dispatcher.
// The optional DEMUX_RR_STATS_EN build adds per-channel delivered-beat counters.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int STAT_W = 16;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } dispatch_state_t;

    // First enabled channel in the order x+1, x+2, x+3, x; returns x when none is enabled.
    function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] x,
                                                 input logic [NUM_CH-1:0] en);
        logic [SEL_W-1:0] idx;
        next_en = x;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = x + SEL_W'(i);
            if (en[idx]) begin
                next_en = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_next_en.sv
// Combinational next-enabled-channel lookup used by the dispatcher's pointer logic.
module rr_next_en
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]  cur,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [SEL_W-1:0]  nxt
);

    always_comb begin
        nxt = next_en(cur, ch_en);
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Burst-interleaved round-robin dispatcher feeding a 1:4 demux with a registered sel/data pair.
// Define DEMUX_RR_STATS_EN to add the stat_beats per-channel delivered-beat counters.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int BURST_LEN = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        ch_ready,
    output logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid
`ifdef DEMUX_RR_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0] stat_beats
`endif
);

    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN);

    dispatch_state_t  state, state_nxt;
    logic [SEL_W-1:0] cur;
    logic [7:0]       bcnt;
    logic [SEL_W-1:0] cur_en_nxt;
    logic [SEL_W-1:0] chosen;
    logic [SEL_W-1:0] cur_after;
    logic [7:0]       eff_cnt;
    logic             burst_done;
    logic             xfer;
    logic             accept;

    assign xfer     = out_valid && ch_ready[sel];
    assign in_ready = (|ch_en) && (!out_valid || ch_ready[sel]);
    assign accept   = in_valid && in_ready;

    rr_next_en u_next_en (
        .cur   (cur),
        .ch_en (ch_en),
        .nxt   (cur_en_nxt)
    );

    // A channel switch restarts the burst; the rotation target after a
    // completed burst is the next enabled channel after the one just used.
    always_comb begin
        chosen     = ch_en[cur] ? cur : cur_en_nxt;
        eff_cnt    = (chosen == cur) ? bcnt + 8'd1 : 8'd1;
        burst_done = (eff_cnt == BURST_LAST);
        cur_after  = (chosen == cur) ? cur_en_nxt : next_en(chosen, ch_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = S_FULL;
        end else if (xfer) begin
            state_nxt = S_EMPTY;
        end
    end

    always_comb begin
        out_valid = (state == S_FULL);
    end

    // Held-beat register stage: sel/out_data only change when a new beat loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            out_data <= '0;
            cur      <= '0;
            bcnt     <= '0;
        end else if (accept) begin
            sel      <= chosen;
            out_data <= in_data;
            if (burst_done) begin
                cur  <= cur_after;
                bcnt <= '0;
            end else begin
                cur  <= chosen;
                bcnt <= eff_cnt;
            end
        end
    end

`ifdef DEMUX_RR_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                stat_q[n] <= '0;
            end
        end else if (xfer) begin
            stat_q[sel] <= stat_q[sel] + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign stat_beats[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed and randomized bench for demux_rr_dispatcher against a queue-free behavioural model.
// Covers the DEMUX_RR_STATS_EN counters when the macro is defined.
module tb_demux_rr_dispatcher;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [3:0]    ch_en;
    logic [3:0]    ch_ready;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic          out_valid;
`ifdef DEMUX_RR_STATS_EN
    logic [63:0]   stat_beats;
`endif

    int vectors = 0;
    int fails   = 0;

    // Behavioural model of the dispatcher
    logic          m_valid;
    logic [1:0]    m_sel;
    logic [DW-1:0] m_data;
    int            m_cur;
    int            m_cnt;
    int            m_stat [4];

    always #5 clk = ~clk;

    demux_rr_dispatcher #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .ch_ready  (ch_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
`ifdef DEMUX_RR_STATS_EN
        ,
        .stat_beats(stat_beats)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int x, input logic [3:0] en);
        for (int off = 1; off <= 4; off++) begin
            if (en[(x + off) % 4]) return (x + off) % 4;
        end
        return x;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sel   = 2'd0;
        m_data  = '0;
        m_cur   = 0;
        m_cnt   = 0;
        for (int n = 0; n < 4; n++) m_stat[n] = 0;
    endtask

`ifdef DEMUX_RR_STATS_EN
    task automatic check_stats(input string tag);
        for (int n = 0; n < 4; n++) begin
            check(tag, 64'(stat_beats[16*n +: 16]), 64'(m_stat[n] % 65536));
        end
    endtask
`endif

    // Asynchronous reset applied mid-cycle, released on a falling edge.
    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        model_reset();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sel", 64'(sel), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(ch_en != 4'h0));
`ifdef DEMUX_RR_STATS_EN
        check_stats("rst_stats");
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive inputs, check in_ready mid-cycle, advance model, check outputs.
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic [3:0] en, input logic [3:0] rdy);
        logic exp_ready;
        logic acc;
        logic xf;
        int   chosen;
        int   cnt;
        in_valid = v;
        in_data  = d;
        ch_en    = en;
        ch_ready = rdy;
        exp_ready = (en != 4'h0) && (!m_valid || rdy[m_sel]);
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        xf  = m_valid && rdy[m_sel];
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        if (xf) m_stat[m_sel]++;
        if (acc) begin
            chosen = en[m_cur] ? m_cur : model_next(m_cur, en);
            cnt    = (chosen == m_cur) ? m_cnt + 1 : 1;
            if (cnt == BL) begin
                m_cur = model_next(chosen, en);
                m_cnt = 0;
            end else begin
                m_cur = chosen;
                m_cnt = cnt;
            end
            m_sel   = 2'(chosen);
            m_data  = d;
            m_valid = 1'b1;
        end else if (xf) begin
            m_valid = 1'b0;
        end
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("sel", 64'(sel), 64'(m_sel));
        check("out_data", 64'(out_data), 64'(m_data));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ch_en    = 4'hF;
        ch_ready = 4'hF;
        model_reset();

        // Reset values, then first beat with 1-cycle latency
        do_reset();
        step(1'b1, 8'hA5, 4'hF, 4'hF);
        check("first_sel", 64'(sel), 64'(0));
        check("first_data", 64'(out_data), 64'hA5);
        check("first_valid", 64'(out_valid), 64'(1));

        // Reset while a beat is held discards it
        do_reset();
        check("rst_discard_valid", 64'(out_valid), 64'(0));

        // Full-rate round-robin: 0x4, 1x4, 2x4, 3x4 with no bubbles
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 4'hF, 4'hF);
            check("rr_sel", 64'(sel), 64'(i / 4));
            check("rr_data", 64'(out_data), 64'(i));
            check("rr_valid", 64'(out_valid), 64'(1));
        end
        step(1'b0, 8'h00, 4'hF, 4'hF);
        check("rr_drain_valid", 64'(out_valid), 64'(0));
`ifdef DEMUX_RR_STATS_EN
        for (int n = 0; n < 4; n++) begin
            check("rr_stat", 64'(stat_beats[16*n +: 16]), 64'(4));
        end
`endif

        // Sparse enables: 1x4, 3x4, 1x4
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(8'h40 + i), 4'b1010, 4'hF);
            check("sparse_sel", 64'(sel), 64'(((i / 4) % 2) ? 3 : 1));
        end
        step(1'b0, 8'h00, 4'b1010, 4'hF);

        // Backpressure on ch0: held beat stable, in_ready low
        do_reset();
        step(1'b1, 8'h77, 4'hF, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h88, 4'hF, 4'b1110);
            check("bp_sel", 64'(sel), 64'(0));
            check("bp_data", 64'(out_data), 64'h77);
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_ready", 64'(in_ready), 64'(0));
        end
        step(1'b1, 8'h99, 4'hF, 4'hF);
        check("bp_next_data", 64'(out_data), 64'h99);
        check("bp_next_sel", 64'(sel), 64'(0));

        // Enable change mid-burst, then all channels disabled
        do_reset();
        step(1'b1, 8'h01, 4'hF, 4'hF);
        step(1'b1, 8'h02, 4'hF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h10 + i), 4'b0100, 4'hF);
            check("en_chg_sel", 64'(sel), 64'(2));
        end
        step(1'b1, 8'h20, 4'h0, 4'h0);
        check("en0_hold_valid", 64'(out_valid), 64'(1));
        check("en0_hold_data", 64'(out_data), 64'h13);
        step(1'b1, 8'h21, 4'h0, 4'hF);
        check("en0_delivered", 64'(out_valid), 64'(0));
        check("en0_ready", 64'(in_ready), 64'(0));

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 400; i++) begin
            logic [3:0] en;
            logic [3:0] rdy;
            if ($urandom_range(0, 79) == 0) do_reset();
            en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ((i / 40) % 2 ? 4'hF : 4'b0110);
            rdy = 4'($urandom) | 4'($urandom);
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), en, rdy);
`ifdef DEMUX_RR_STATS_EN
            if (i % 50 == 49) check_stats("rand_stats");
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
